tlb_op_ctrl: RTL and testbench
==============================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16: number of TLB entries, power of two, 4..64.
REQ-002 SHALL have parameter IDX_W, default 4: index width, log2(TLB_ENTRIES).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 op_valid  in  1  committed TLB instruction request.
REQ-006 op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-007 op_ready  out  1  controller idle, can accept.
REQ-008 index_i  in  IDX_W  CP0 Index field.
REQ-009 wired_i  in  IDX_W  CP0 Wired field.
REQ-010 wired_we  in  1  CP0 Wired being written this cycle.
REQ-011 tlb_re / tlb_we  out  1 each  TLB array read / write strobe.
REQ-012 tlb_addr  out  IDX_W  TLB array entry address.
REQ-013 probe_req  out  1  start TLB probe with current EntryHi.
REQ-014 probe_hit  in  1 / probe_idx  in  IDX_W  probe result, valid cycle after probe_req.
REQ-015 index_we  out  1 / index_wdata  out  32  CP0 Index update: bit31 = P (miss), [IDX_W-1:0] = idx, rest 0.
REQ-016 entry_we  out  1  load EntryHi/EntryLo0/EntryLo1/PageMask from the array read data latched by CP0.
REQ-017 random_o  out  IDX_W  CP0 Random value.
REQ-018 done  out  1  one-cycle pulse, operation complete.
REQ-019 flush  out  1  one-cycle pulse with done after a write, refetch/invalidate translations.
REQ-020 stall  out  1  asserted while op in flight (not IDLE).

Function
REQ-021 States: IDLE, ISSUE, WAIT, FIN; IDLE->ISSUE on op_valid & op_ready; ISSUE->WAIT->FIN->IDLE unconditionally, fixed 3-cycle latency.
REQ-022 op_ready = (state==IDLE); stall = !op_ready; op_valid while not ready is ignored, not queued.
REQ-023 Accept cycle T: op_code, index_i and random_o sampled into registers; later changes of inputs do not affect the op.
REQ-024 TLBP: T+1 probe_req=1; T+2 probe_hit/probe_idx captured; T+3 index_we=1, index_wdata = hit ? {0,probe_idx} : {1,0...}.
REQ-025 TLBR: T+1 tlb_re=1, tlb_addr=latched index; T+3 entry_we=1.
REQ-026 TLBWI: T+1 tlb_we=1, tlb_addr=latched index; T+3 flush=1.
REQ-027 TLBWR: as TLBWI with tlb_addr=latched random.
REQ-028 done=1 at T+3 for every op; all strobes single-cycle, 0 otherwise; tlb_addr=0 when no strobe.
REQ-029 Latched index >= TLB_ENTRIES (only if IDX_W exceeds log2 range): strobes and entry_we suppressed, done still pulses.
REQ-030 Random: decrements by 1 every clock; when random_o <= wired_i it loads TLB_ENTRIES-1 next cycle instead.
REQ-031 wired_i >= TLB_ENTRIES-1: random_o held at TLB_ENTRIES-1.
REQ-032 wired_we: random_o loads TLB_ENTRIES-1 next cycle, priority over decrement/wrap.
REQ-033 Random keeps counting during ops; TLBWR uses value sampled at T.
REQ-034 Back-to-back: new op accepted earliest cycle T+4 (IDLE after FIN).

Reset
REQ-035 On rst: state IDLE, op_ready=1, stall=0, all strobes/done/flush/index_we/entry_we=0, index_wdata=0, tlb_addr=0, random_o=TLB_ENTRIES-1.
REQ-036 rst mid-operation aborts immediately; no strobe, done or flush issued after release.

Verification
REQ-037 TLBP, EntryHi matches, probe_hit=1 probe_idx=5 at T+2 -> T+3 index_we=1, index_wdata=0x00000005, done=1.
REQ-038 TLBP miss, probe_hit=0 -> T+3 index_wdata=0x80000000.
REQ-039 TLBWI index_i=3, index_i changed to 9 at T+1 -> tlb_we at T+1 with tlb_addr=3; flush+done at T+3.
REQ-040 wired_i=12, no ops, from reset -> random_o sequence 15,14,13,12,15,14...; wired_we pulse -> 15 next cycle.
REQ-041 TLBWR accepted with random_o=7 -> tlb_we T+1, tlb_addr=7, regardless of random_o at T+1.
REQ-042 TLBR issued, rst at T+2 -> entry_we and done never assert; op_ready=1 after release.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: runs TLBP/TLBR/TLBWI/TLBWR as a fixed 3-cycle
// operation against the TLB array and CP0, and maintains the CP0 Random counter.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    output logic             op_ready,
    input  logic [IDX_W-1:0] index_i,
    input  logic [IDX_W-1:0] wired_i,
    input  logic             wired_we,
    output logic             tlb_re,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_addr,
    output logic             probe_req,
    input  logic             probe_hit,
    input  logic [IDX_W-1:0] probe_idx,
    output logic             index_we,
    output logic [31:0]      index_wdata,
    output logic             entry_we,
    output logic [IDX_W-1:0] random_o,
    output logic             done,
    output logic             flush,
    output logic             stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_e;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } op_e;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] rnd_q, rnd_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] pidx_q, pidx_d;
    logic [IDX_W-1:0] random_q, random_d;

    logic [IDX_W-1:0] target_addr;
    logic             target_ok;
    logic             wired_full;

    // NOTE: every register uses <= so all flops see pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_TLBP;
            index_q  <= '0;
            rnd_q    <= '0;
            hit_q    <= 1'b0;
            pidx_q   <= '0;
            random_q <= MAX_IDX;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            index_q  <= index_d;
            rnd_q    <= rnd_d;
            hit_q    <= hit_d;
            pidx_q   <= pidx_d;
            random_q <= random_d;
        end
    end

    // NOTE: each always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        index_d = index_q;
        rnd_d   = rnd_q;
        hit_d   = hit_q;
        pidx_d  = pidx_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    state_d = S_ISSUE;
                    op_d    = op_e'(op_code);
                    index_d = index_i;
                    rnd_d   = random_q;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_FIN;
                if (op_q == OP_TLBP) begin
                    hit_d  = probe_hit;
                    pidx_d = probe_idx;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Wired writes and the wired-covers-everything case both pin Random at the top entry.
    assign wired_full = int'(wired_i) >= (TLB_ENTRIES - 1);

    always_comb begin
        random_d = random_q - 1'b1;
        if (wired_we || wired_full || (random_q <= wired_i)) begin
            random_d = MAX_IDX;
        end
    end

    assign target_addr = (op_q == OP_TLBWR) ? rnd_q : index_q;
    assign target_ok   = int'(target_addr) < TLB_ENTRIES;

    always_comb begin
        tlb_re      = 1'b0;
        tlb_we      = 1'b0;
        tlb_addr    = '0;
        probe_req   = 1'b0;
        index_we    = 1'b0;
        index_wdata = '0;
        entry_we    = 1'b0;
        done        = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
                if (op_q == OP_TLBP) begin
                    probe_req = 1'b1;
                end else if (target_ok) begin
                    tlb_re   = (op_q == OP_TLBR);
                    tlb_we   = (op_q != OP_TLBR);
                    tlb_addr = target_addr;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (op_q == OP_TLBP) begin
                    index_we    = 1'b1;
                    index_wdata = hit_q ? 32'(pidx_q) : 32'h8000_0000;
                end else if (target_ok) begin
                    entry_we = (op_q == OP_TLBR);
                    flush    = (op_q != OP_TLBR);
                end
            end
            default: ;
        endcase
    end

    assign op_ready = (state_q == S_IDLE);
    assign stall    = !op_ready;
    assign random_o = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a timeline model.
module tb_tlb_op_ctrl;

    localparam int N    = 16;
    localparam int W    = 4;
    localparam int MAXI = N - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [1:0]   op_code;
    logic         op_ready;
    logic [W-1:0] index_i;
    logic [W-1:0] wired_i;
    logic         wired_we;
    logic         tlb_re;
    logic         tlb_we;
    logic [W-1:0] tlb_addr;
    logic         probe_req;
    logic         probe_hit;
    logic [W-1:0] probe_idx;
    logic         index_we;
    logic [31:0]  index_wdata;
    logic         entry_we;
    logic [W-1:0] random_o;
    logic         done;
    logic         flush;
    logic         stall;

    tlb_op_ctrl #(.TLB_ENTRIES(N), .IDX_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_ready    (op_ready),
        .index_i     (index_i),
        .wired_i     (wired_i),
        .wired_we    (wired_we),
        .tlb_re      (tlb_re),
        .tlb_we      (tlb_we),
        .tlb_addr    (tlb_addr),
        .probe_req   (probe_req),
        .probe_hit   (probe_hit),
        .probe_idx   (probe_idx),
        .index_we    (index_we),
        .index_wdata (index_wdata),
        .entry_we    (entry_we),
        .random_o    (random_o),
        .done        (done),
        .flush       (flush),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: an accepted op is a record stamped with its accept cycle; outputs
    // are a function of how many cycles have elapsed since that stamp.
    bit have;
    int acc_t;
    int m_op, m_idx, m_rnd, m_pidx;
    bit m_hit;
    int m_rand;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        have   = 1'b0;
        m_rand = MAXI;
    endtask

    task automatic model_update();
        bit busy;
        if (rst) begin
            model_reset();
        end else begin
            busy = have && (cyc >= acc_t + 1) && (cyc <= acc_t + 3);
            if (!busy && op_valid) begin
                have  = 1'b1;
                acc_t = cyc;
                m_op  = int'(op_code);
                m_idx = int'(index_i);
                m_rnd = m_rand;
            end else if (have && cyc == acc_t + 2) begin
                m_hit  = probe_hit;
                m_pidx = int'(probe_idx);
            end
            if (wired_we || int'(wired_i) >= MAXI || m_rand <= int'(wired_i)) m_rand = MAXI;
            else m_rand = m_rand - 1;
        end
        cyc++;
    endtask

    task automatic compare_outputs();
        int d;
        logic e_probe, e_re, e_we, e_iwe, e_ewe, e_done, e_flush, e_ready;
        logic [31:0] e_addr, e_wdata;
        d = have ? cyc - acc_t : 0;
        {e_probe, e_re, e_we, e_iwe, e_ewe, e_done, e_flush} = '0;
        e_addr  = 0;
        e_wdata = 0;
        e_ready = !(have && d >= 1 && d <= 3);
        if (have && d == 1) begin
            case (m_op)
                0: e_probe = 1'b1;
                1: begin e_re = 1'b1; e_addr = m_idx; end
                2: begin e_we = 1'b1; e_addr = m_idx; end
                default: begin e_we = 1'b1; e_addr = m_rnd; end
            endcase
        end
        if (have && d == 3) begin
            e_done = 1'b1;
            case (m_op)
                0: begin e_iwe = 1'b1; e_wdata = m_hit ? 32'(m_pidx) : 32'h8000_0000; end
                1: e_ewe = 1'b1;
                default: e_flush = 1'b1;
            endcase
        end
        check("op_ready", op_ready, e_ready);
        check("stall", stall, !e_ready);
        check("probe_req", probe_req, e_probe);
        check("tlb_re", tlb_re, e_re);
        check("tlb_we", tlb_we, e_we);
        check("tlb_addr", tlb_addr, e_addr);
        check("index_we", index_we, e_iwe);
        check("index_wdata", index_wdata, e_wdata);
        check("entry_we", entry_we, e_ewe);
        check("done", done, e_done);
        check("flush", flush, e_flush);
        check("random_o", random_o, m_rand);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_outputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq[5] = '{14, 13, 12, 15, 14};
        int k;
        rst = 1'b1; op_valid = 1'b0; op_code = 2'd0; index_i = '0;
        wired_i = '0; wired_we = 1'b0; probe_hit = 1'b0; probe_idx = '0;
        model_reset();
        repeat (2) step();
        rst = 1'b0;

        check("reset_ready", op_ready, 1);
        check("reset_stall", stall, 0);
        check("reset_random", random_o, 15);
        check("reset_wdata", index_wdata, 0);
        check("reset_addr", tlb_addr, 0);
        check("reset_done", done, 0);

        // Random sequence with wired=12, then a Wired write reload
        wired_i = 4'd12;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rand_seq", random_o, seq[i]);
        end
        wired_we = 1'b1;
        step();
        wired_we = 1'b0;
        check("wired_we_load", random_o, 15);
        step();
        check("after_wired_we", random_o, 14);
        wired_i = '0;

        // TLBP hit on entry 5
        op_valid = 1'b1; op_code = 2'b00;
        step();
        op_valid = 1'b0;
        check("tlbp_probe_req", probe_req, 1);
        step();
        probe_hit = 1'b1; probe_idx = 4'd5;
        step();
        probe_hit = 1'b0; probe_idx = '0;
        check("tlbp_hit_we", index_we, 1);
        check("tlbp_hit_wdata", index_wdata, 32'h0000_0005);
        check("tlbp_hit_done", done, 1);
        step();

        // TLBP miss
        op_valid = 1'b1; op_code = 2'b00;
        step();
        op_valid = 1'b0;
        step();
        probe_hit = 1'b0; probe_idx = 4'd9;
        step();
        check("tlbp_miss_wdata", index_wdata, 32'h8000_0000);
        step();

        // TLBWI with index changing after acceptance
        op_valid = 1'b1; op_code = 2'b10; index_i = 4'd3;
        step();
        op_valid = 1'b0; index_i = 4'd9;
        check("tlbwi_we", tlb_we, 1);
        check("tlbwi_addr", tlb_addr, 3);
        step();
        check("tlbwi_we_single", tlb_we, 0);
        step();
        check("tlbwi_flush", flush, 1);
        check("tlbwi_done", done, 1);
        check("tlbwi_busy_fin", op_ready, 0);
        step();
        check("tlbwi_ready_t4", op_ready, 1);

        // TLBWR accepted while Random reads 7
        k = 0;
        while (m_rand != 7 && k < 40) begin
            step();
            k++;
        end
        check("tlbwr_rand_at_accept", random_o, 7);
        op_valid = 1'b1; op_code = 2'b11; index_i = 4'd2;
        step();
        op_valid = 1'b0;
        check("tlbwr_we", tlb_we, 1);
        check("tlbwr_addr", tlb_addr, 7);
        check("tlbwr_rand_moved", random_o, 6);
        repeat (3) step();

        // TLBR aborted by reset at T+2
        op_valid = 1'b1; op_code = 2'b01; index_i = 4'd4;
        step();
        op_valid = 1'b0;
        check("tlbr_re", tlb_re, 1);
        check("tlbr_addr", tlb_addr, 4);
        step();
        rst = 1'b1;
        #1;
        check("abort_ready_async", op_ready, 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_entry_we", entry_we, 0);
            check("abort_no_done", done, 0);
            check("abort_ready", op_ready, 1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            op_valid  = ($urandom_range(0, 2) != 0);
            op_code   = 2'($urandom_range(0, 3));
            index_i   = W'($urandom_range(0, N - 1));
            probe_hit = 1'($urandom_range(0, 1));
            probe_idx = W'($urandom_range(0, N - 1));
            if ($urandom_range(0, 15) == 0) wired_i = W'($urandom_range(0, N - 1));
            wired_we  = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        op_valid = 1'b0;
        wired_we = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
